decode_hazard_controller: RTL and testbench
===========================================

Name: decode_hazard_controller

Overview:
- Decode-stage controller for the RV32i 5-stage pipeline.
- Classifies the instruction in ID and drives Imm_Type_Sel to the immediate extender.
- Owns the control half of the ID/EX pipeline register and detects load-use hazards.
- Arbitrates stall/flush between load-use hazards, taken-branch redirects from EX and external data-memory stalls; counts hazard stall cycles.

Parameters:
- CNT_W, 16, width of saturating load-use stall counter

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  synchronous active-low reset
- Instr_D  in  32  instruction held in IF/ID register
- Valid_D  in  1  Instr_D is a real instruction (not a bubble)
- Branch_Taken_E  in  1  EX resolved a taken branch/jump; redirect this cycle
- Stall_Ext  in  1  data memory not ready; freeze whole pipeline
- Imm_Type_Sel  out  3  combinational select to extender: IMM_I=0, IMM_S=1, IMM_B=2, IMM_U=3, IMM_J=4
- Stall_F  out  1  hold PC
- Stall_D  out  1  hold IF/ID
- Flush_D  out  1  clear IF/ID on next edge
- Flush_E  out  1  ID/EX receives bubble on next edge
- Valid_E  out  1  registered: EX holds a real instruction
- Rd_E  out  5  registered destination register
- Mem_Read_E  out  1  registered: EX instruction is a load
- Reg_Write_E  out  1  registered: EX instruction writes rd
- Imm_Type_E  out  3  registered Imm_Type_Sel
- Illegal_D  out  1  combinational: Valid_D and opcode not RV32i
- Stall_Count  out  CNT_W  load-use stall cycles, saturating

Behaviour:
- Opcode decode (Instr_D[6:0]):
  - 0010011/0000011/1100111/1110011/0001111 -> IMM_I
  - 0100011 -> IMM_S; 1100011 -> IMM_B; 0110111/0010111 -> IMM_U; 1101111 -> IMM_J
  - 0110011 (R-type) -> IMM_I (don't-care, fixed at 0)
  - Any other opcode -> IMM_I with Illegal_D=Valid_D.
- Register usage:
  - rs1 = Instr_D[19:15], used by R, I-ALU, load, JALR, S, B.
  - rs2 = Instr_D[24:20], used by R, S, B.
  - U, JAL, SYSTEM and FENCE use none.
- Reg_Write: R, I-ALU, load, JALR, JAL, LUI, AUIPC.
- Rd_E is captured as 0 when Reg_Write is 0.
- Load-use hazard (LU) = Valid_D & Valid_E & Mem_Read_E & (Rd_E!=0) & ((uses_rs1 & rs1==Rd_E) | (uses_rs2 & rs2==Rd_E)).
- FSM states RUN, HOLD.
  - RUN -> HOLD when Stall_Ext=1. HOLD -> RUN when Stall_Ext=0.
  - In HOLD: Stall_F=Stall_D=1, Flush_D=Flush_E=0, ID/EX register and Stall_Count frozen.
  - The HOLD outputs apply in any cycle where Stall_Ext=1, including the cycle of entry.
- Priority when Stall_Ext=0 (highest first):
  1. Branch_Taken_E: Flush_D=1, Flush_E=1, Stall_F=Stall_D=0. LU is ignored.
  2. LU: Stall_F=Stall_D=1, Flush_E=1, Flush_D=0, Stall_Count += 1 (saturates at all-ones).
  3. Otherwise all four controls are 0.
- ID/EX update, one-cycle latency, posedge, only when not held:
  - Flush_E=1 -> Valid_E=0, Mem_Read_E=0, Reg_Write_E=0, Rd_E=0, Imm_Type_E=0.
  - Else -> capture Valid_D and the decoded fields. Illegal instructions are captured with Reg_Write_E=0 and Mem_Read_E=0.
- LU holds for exactly one cycle: the bubble clears Mem_Read_E.
- A branch redirect arriving during HOLD takes effect in the first cycle after Stall_Ext falls, since EX is frozen and Branch_Taken_E stays asserted.
- Reset (RST_N=0 at posedge):
  - State=RUN.
  - Valid_E=0, Rd_E=0, Mem_Read_E=0, Reg_Write_E=0, Imm_Type_E=0, Stall_Count=0.
  - Combinational outputs follow their inputs.
  - Reset mid-stall discards the stall; the first post-reset cycle is RUN.
- Imm_Type_Sel and Illegal_D are purely combinational from Instr_D. Imm_Type_Sel is valid even when Valid_D=0.

Test Plan:
- Decode sweep: Instr_D = 0x00A00093 (addi), 0x00112023 (sw), 0x00208463 (beq), 0x000012B7 (lui), 0x008000EF (jal) -> Imm_Type_Sel = 0, 1, 2, 3, 4; Illegal_D=0. Instr_D=0x0000007F, Valid_D=1 -> Illegal_D=1.
- Load-use:
  - Setup: cycle N captures lw x5,0(x1) (0x0000A283) into E; cycle N+1 Instr_D=add x6,x5,x2 (0x00228333).
  - At N+1: Stall_F=Stall_D=Flush_E=1.
  - At N+2: Valid_E=0, no stall; Stall_Count=1.
  - With rd=x0 (0x00002003), or a consumer not using x5: no stall.
- Branch priority: LU condition and Branch_Taken_E=1 in the same cycle -> Flush_D=Flush_E=1, Stall_F=0, Stall_Count unchanged.
- External stall: Stall_Ext=1 for 3 cycles with Branch_Taken_E=1 -> Stall_F=Stall_D=1 and no flush for 3 cycles, ID/EX frozen. In the 4th cycle: Flush_D=Flush_E=1.
- Saturation: CNT_W=4, drive 20 consecutive load-use pairs -> Stall_Count stops at 15.
- Reset mid-operation: RST_N=0 during an active LU stall -> next cycle Valid_E=0, Stall_Count=0, no stall asserted.

Source files
------------

// File: rtl/decode_hazard_controller.sv
// rtl/decode_hazard_controller.sv - RV32i ID-stage decode, ID/EX control register and hazard arbitration
module decode_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [31:0]      Instr_D,
  input  logic             Valid_D,
  input  logic             Branch_Taken_E,
  input  logic             Stall_Ext,
  output logic [2:0]       Imm_Type_Sel,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             Valid_E,
  output logic [4:0]       Rd_E,
  output logic             Mem_Read_E,
  output logic             Reg_Write_E,
  output logic [2:0]       Imm_Type_E,
  output logic             Illegal_D,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  typedef enum logic {RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic             valid_e_q, valid_e_d;
  logic [4:0]       rd_e_q, rd_e_d;
  logic             mem_read_e_q, mem_read_e_d;
  logic             reg_write_e_q, reg_write_e_d;
  logic [2:0]       imm_type_e_q, imm_type_e_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       uses_rs1, uses_rs2, reg_write, mem_read, illegal_op;
  logic [2:0] imm_sel;
  logic [4:0] rs1, rs2, rd;
  logic       load_use, hold, count_stall;
  logic       unused_bits;

  assign rs1 = Instr_D[19:15];
  assign rs2 = Instr_D[24:20];
  assign rd  = Instr_D[11:7];
  assign unused_bits = ^{Instr_D[31:25], Instr_D[14:12]};

  always_comb begin
    imm_sel    = IMM_I;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    illegal_op = 1'b0;
    case (Instr_D[6:0])
      7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; reg_write = 1'b1; end
      7'b0010011: begin uses_rs1 = 1'b1; reg_write = 1'b1; end
      7'b0000011: begin uses_rs1 = 1'b1; reg_write = 1'b1; mem_read = 1'b1; end
      7'b1100111: begin uses_rs1 = 1'b1; reg_write = 1'b1; end
      7'b1110011, 7'b0001111: imm_sel = IMM_I;
      7'b0100011: begin imm_sel = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b1100011: begin imm_sel = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0110111, 7'b0010111: begin imm_sel = IMM_U; reg_write = 1'b1; end
      7'b1101111: begin imm_sel = IMM_J; reg_write = 1'b1; end
      default: illegal_op = 1'b1;
    endcase
  end

  assign Imm_Type_Sel = imm_sel;
  assign Illegal_D    = Valid_D & illegal_op;

  assign load_use = Valid_D & valid_e_q & mem_read_e_q & (rd_e_q != 5'd0) &
                    ((uses_rs1 & (rs1 == rd_e_q)) | (uses_rs2 & (rs2 == rd_e_q)));

  // HOLD outputs follow Stall_Ext directly so the entry cycle is already frozen.
  always_comb begin
    state_d     = state_q;
    hold        = 1'b0;
    Stall_F     = 1'b0;
    Stall_D     = 1'b0;
    Flush_D     = 1'b0;
    Flush_E     = 1'b0;
    count_stall = 1'b0;
    case (state_q)
      RUN:     if (Stall_Ext) state_d = HOLD;
      HOLD:    if (!Stall_Ext) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (Stall_Ext) begin
      hold    = 1'b1;
      Stall_F = 1'b1;
      Stall_D = 1'b1;
    end else if (Branch_Taken_E) begin
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (load_use) begin
      Stall_F     = 1'b1;
      Stall_D     = 1'b1;
      Flush_E     = 1'b1;
      count_stall = 1'b1;
    end
  end

  always_comb begin
    valid_e_d     = valid_e_q;
    rd_e_d        = rd_e_q;
    mem_read_e_d  = mem_read_e_q;
    reg_write_e_d = reg_write_e_q;
    imm_type_e_d  = imm_type_e_q;
    cnt_d         = cnt_q;
    if (!hold) begin
      if (Flush_E) begin
        valid_e_d     = 1'b0;
        rd_e_d        = 5'd0;
        mem_read_e_d  = 1'b0;
        reg_write_e_d = 1'b0;
        imm_type_e_d  = IMM_I;
      end else begin
        valid_e_d     = Valid_D;
        reg_write_e_d = Valid_D & reg_write;
        mem_read_e_d  = Valid_D & mem_read;
        rd_e_d        = (Valid_D & reg_write) ? rd : 5'd0;
        imm_type_e_d  = imm_sel;
      end
      if (count_stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= RUN;
      valid_e_q     <= 1'b0;
      rd_e_q        <= 5'd0;
      mem_read_e_q  <= 1'b0;
      reg_write_e_q <= 1'b0;
      imm_type_e_q  <= IMM_I;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      valid_e_q     <= valid_e_d;
      rd_e_q        <= rd_e_d;
      mem_read_e_q  <= mem_read_e_d;
      reg_write_e_q <= reg_write_e_d;
      imm_type_e_q  <= imm_type_e_d;
      cnt_q         <= cnt_d;
    end
  end

  assign Valid_E     = valid_e_q;
  assign Rd_E        = rd_e_q;
  assign Mem_Read_E  = mem_read_e_q;
  assign Reg_Write_E = reg_write_e_q;
  assign Imm_Type_E  = imm_type_e_q;
  assign Stall_Count = cnt_q;

endmodule

// File: tb/tb_decode_hazard_controller.sv
// tb/tb_decode_hazard_controller.sv - directed self-checking bench for decode_hazard_controller
module tb_decode_hazard_controller;

  localparam logic [31:0] LW_X5   = 32'h0000A283;
  localparam logic [31:0] ADD_USE = 32'h00228333;
  localparam logic [31:0] ADD_NO  = 32'h00208333;
  localparam logic [31:0] LW_X0   = 32'h00002003;
  localparam logic [31:0] ADD_X0  = 32'h00000333;
  localparam logic [31:0] LUI_X5  = 32'h000282B7;
  localparam logic [31:0] ADDI    = 32'h00A00093;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] Instr_D;
  logic        Valid_D, Branch_Taken_E, Stall_Ext;
  logic [2:0]  Imm_Type_Sel, Imm_Type_E;
  logic        Stall_F, Stall_D, Flush_D, Flush_E, Valid_E, Mem_Read_E, Reg_Write_E, Illegal_D;
  logic [4:0]  Rd_E;
  logic [3:0]  Stall_Count;

  int errors = 0;
  int checks = 0;

  decode_hazard_controller #(.CNT_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .Instr_D(Instr_D), .Valid_D(Valid_D),
    .Branch_Taken_E(Branch_Taken_E), .Stall_Ext(Stall_Ext),
    .Imm_Type_Sel(Imm_Type_Sel), .Stall_F(Stall_F), .Stall_D(Stall_D),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Valid_E(Valid_E), .Rd_E(Rd_E),
    .Mem_Read_E(Mem_Read_E), .Reg_Write_E(Reg_Write_E), .Imm_Type_E(Imm_Type_E),
    .Illegal_D(Illegal_D), .Stall_Count(Stall_Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic sf, input logic sd, input logic fd, input logic fe);
    chk({tag, ".Stall_F"}, 32'(Stall_F), 32'(sf));
    chk({tag, ".Stall_D"}, 32'(Stall_D), 32'(sd));
    chk({tag, ".Flush_D"}, 32'(Flush_D), 32'(fd));
    chk({tag, ".Flush_E"}, 32'(Flush_E), 32'(fe));
  endtask

  initial begin
    RST_N = 1'b0; Instr_D = 32'h0; Valid_D = 1'b0; Branch_Taken_E = 1'b0; Stall_Ext = 1'b0;
    tick(); tick();
    chk("rst.Valid_E", 32'(Valid_E), 0);
    chk("rst.Rd_E", 32'(Rd_E), 0);
    chk("rst.Mem_Read_E", 32'(Mem_Read_E), 0);
    chk("rst.Reg_Write_E", 32'(Reg_Write_E), 0);
    chk("rst.Imm_Type_E", 32'(Imm_Type_E), 0);
    chk("rst.Stall_Count", 32'(Stall_Count), 0);
    chk_ctrl("rst", 0, 0, 0, 0);
    RST_N = 1'b1;

    // decode sweep
    Valid_D = 1'b1;
    Instr_D = 32'h00A00093; settle(); chk("dec.addi", 32'(Imm_Type_Sel), 0); chk("dec.addi.ill", 32'(Illegal_D), 0);
    Instr_D = 32'h00112023; settle(); chk("dec.sw", 32'(Imm_Type_Sel), 1); chk("dec.sw.ill", 32'(Illegal_D), 0);
    Instr_D = 32'h00208463; settle(); chk("dec.beq", 32'(Imm_Type_Sel), 2); chk("dec.beq.ill", 32'(Illegal_D), 0);
    Instr_D = 32'h000012B7; settle(); chk("dec.lui", 32'(Imm_Type_Sel), 3); chk("dec.lui.ill", 32'(Illegal_D), 0);
    Instr_D = 32'h008000EF; settle(); chk("dec.jal", 32'(Imm_Type_Sel), 4); chk("dec.jal.ill", 32'(Illegal_D), 0);
    tick();
    chk("jal.Rd_E", 32'(Rd_E), 1);
    chk("jal.Reg_Write_E", 32'(Reg_Write_E), 1);
    chk("jal.Imm_Type_E", 32'(Imm_Type_E), 4);
    Instr_D = 32'h0000007F; settle(); chk("dec.bad.ill", 32'(Illegal_D), 1); chk("dec.bad.imm", 32'(Imm_Type_Sel), 0);
    tick();
    chk("bad.Valid_E", 32'(Valid_E), 1);
    chk("bad.Reg_Write_E", 32'(Reg_Write_E), 0);
    chk("bad.Mem_Read_E", 32'(Mem_Read_E), 0);
    Valid_D = 1'b0; settle(); chk("dec.bad.nv.ill", 32'(Illegal_D), 0);
    Instr_D = 32'h00112023; settle(); chk("dec.sw.nv", 32'(Imm_Type_Sel), 1);
    Valid_D = 1'b1;

    // load-use
    Instr_D = LW_X5; tick();
    chk("lw.Valid_E", 32'(Valid_E), 1);
    chk("lw.Rd_E", 32'(Rd_E), 5);
    chk("lw.Mem_Read_E", 32'(Mem_Read_E), 1);
    chk("lw.Reg_Write_E", 32'(Reg_Write_E), 1);
    Instr_D = ADD_USE; settle();
    chk_ctrl("lu", 1, 1, 0, 1);
    tick();
    chk("lu+1.Valid_E", 32'(Valid_E), 0);
    chk("lu+1.Mem_Read_E", 32'(Mem_Read_E), 0);
    chk("lu+1.Stall_Count", 32'(Stall_Count), 1);
    chk_ctrl("lu+1", 0, 0, 0, 0);
    tick();
    chk("add.Rd_E", 32'(Rd_E), 6);
    chk("add.Valid_E", 32'(Valid_E), 1);

    Instr_D = LW_X0; tick();
    chk("lwx0.Rd_E", 32'(Rd_E), 0);
    Instr_D = ADD_X0; settle(); chk_ctrl("lux0", 0, 0, 0, 0);
    Instr_D = LW_X5; tick();
    Instr_D = ADD_NO; settle(); chk_ctrl("nouse", 0, 0, 0, 0);
    Instr_D = LUI_X5; settle(); chk_ctrl("lui_nors", 0, 0, 0, 0);
    Instr_D = ADD_USE; Valid_D = 1'b0; settle(); chk_ctrl("bubble", 0, 0, 0, 0);
    Valid_D = 1'b1; settle(); chk_ctrl("lu_again", 1, 1, 0, 1);

    // branch beats load-use
    Branch_Taken_E = 1'b1; settle();
    chk_ctrl("br", 0, 0, 1, 1);
    tick();
    Branch_Taken_E = 1'b0;
    chk("br.Stall_Count", 32'(Stall_Count), 1);
    chk("br.Valid_E", 32'(Valid_E), 0);

    // external stall with pending redirect
    Instr_D = LW_X5; tick();
    Instr_D = ADDI; Stall_Ext = 1'b1; Branch_Taken_E = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_ctrl($sformatf("ext%0d", i), 1, 1, 0, 0);
      tick();
      chk($sformatf("ext%0d.Valid_E", i), 32'(Valid_E), 1);
      chk($sformatf("ext%0d.Rd_E", i), 32'(Rd_E), 5);
      chk($sformatf("ext%0d.Mem_Read_E", i), 32'(Mem_Read_E), 1);
    end
    Stall_Ext = 1'b0; settle();
    chk_ctrl("ext_rel", 0, 0, 1, 1);
    tick();
    Branch_Taken_E = 1'b0;
    chk("ext_rel.Valid_E", 32'(Valid_E), 0);
    chk("ext_rel.Stall_Count", 32'(Stall_Count), 1);

    // saturation
    for (int i = 0; i < 20; i++) begin
      Instr_D = LW_X5; tick();
      Instr_D = ADD_USE; tick();
      if (i == 12) chk("sat.pre", 32'(Stall_Count), 14);
    end
    chk("sat.final", 32'(Stall_Count), 15);

    // reset in the middle of a load-use stall
    Instr_D = LW_X5; tick();
    Instr_D = ADD_USE; settle(); chk("rst_lu.Stall_F", 32'(Stall_F), 1);
    RST_N = 1'b0; tick();
    chk("rst_lu.Valid_E", 32'(Valid_E), 0);
    chk("rst_lu.Mem_Read_E", 32'(Mem_Read_E), 0);
    chk("rst_lu.Stall_Count", 32'(Stall_Count), 0);
    chk_ctrl("rst_lu", 0, 0, 0, 0);
    RST_N = 1'b1; tick();
    chk("post_rst.Rd_E", 32'(Rd_E), 6);
    chk("post_rst.Stall_Count", 32'(Stall_Count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
